// File: rtl/censor_out_tx.sv
// UART 8N1 transmitter for the censor pipeline, fed by a small circular character FIFO.
// NUL characters from the masking stage are silently discarded before buffering.
module censor_out_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [BW-1:0]   baud_cnt, baud_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            tx_next, busy_next;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            wr_req, wr_en, pop;

    assign wr_req     = char_valid && (char_in != 8'h00);
    assign fifo_full  = (count == DEPTH_C);
    assign wr_en      = wr_req && (!fifo_full || pop);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= char_in;
    end

    // A full FIFO still accepts a write on the edge that pops, since a slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (wr_req && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            tx_busy   <= busy_next;
        end
    end

    // Pops use the count registered before this edge, so a fresh write is never popped on its own edge.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        tx_next    = tx;
        busy_next  = tx_busy;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    baud_next  = '0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_censor_out_tx.sv
// Directed bench for censor_out_tx: a negedge line monitor captures each 40-cycle frame
// and the scenario tasks compare frames, timing and FIFO flags against hand-computed values.
module tb_censor_out_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       tx, tx_busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [39:0] txq[$];
    logic [39:0] busyq[$];
    int          startq[$];

    logic [39:0] mon_tx, mon_busy;
    int          mon_n = 0;
    int          mon_start = 0;
    bit          mon_active = 1'b0;

    censor_out_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Samples the line once per cycle on the falling edge; a frame begins at the first low sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            mon_n = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_tx = '0;
                mon_busy = '0;
                mon_tx[0] = tx;
                mon_busy[0] = tx_busy;
                mon_n = 1;
                mon_start = cyc;
            end
        end else begin
            mon_tx[mon_n] = tx;
            mon_busy[mon_n] = tx_busy;
            mon_n++;
            if (mon_n == 40) begin
                txq.push_back(mon_tx);
                busyq.push_back(mon_busy);
                startq.push_back(mon_start);
                mon_active = 1'b0;
            end
        end
    end

    function automatic logic [39:0] frame_of(input logic [7:0] c);
        logic [39:0] f;
        f = '0;
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++)
                f[4 + 4*b + k] = c[b];
        for (int k = 36; k < 40; k++)
            f[k] = 1'b1;
        return f;
    endfunction

    task automatic write_char(input logic [7:0] c, output int acc);
        @(negedge clk);
        char_in = c;
        char_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        char_valid = 1'b0;
        char_in = 8'h00;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60*n + 100; i++) begin
            @(posedge clk);
            if (txq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        char_valid = 1'b0;
        char_in = 8'h00;
        repeat (3) @(negedge clk);
        txq.delete();
        busyq.delete();
        startq.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_tx got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count got %0d exp 0", fifo_count); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL rst_full got %b exp 0", fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got %b exp 0", overflow); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_char();
        int acc, st;
        bit ok;
        logic [39:0] f, b;
        write_char(8'h41, acc);
        wait_frames(1, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL t1_timeout got 0 frames exp 1"); return; end
        f = txq.pop_front(); b = busyq.pop_front(); st = startq.pop_front();
        checks++; if (f !== frame_of(8'h41)) begin errors++; $display("[TB] FAIL t1_frame got %h exp %h", f, frame_of(8'h41)); end
        checks++; if (b !== {40{1'b1}}) begin errors++; $display("[TB] FAIL t1_busy got %h exp ffffffffff", b); end
        checks++; if (st - acc !== 1) begin errors++; $display("[TB] FAIL t1_latency got %0d exp 1", st - acc); end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_end got %b exp 0", tx_busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL t1_idle_tx got %b exp 1", tx); end
    endtask

    task automatic test_back_to_back();
        int acc, s1, s2;
        bit ok;
        logic [39:0] f1, f2, b;
        @(negedge clk); char_valid = 1'b1; char_in = 8'h00;
        @(negedge clk);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL t2_nul_count got %0d exp 0", fifo_count); end
        char_in = 8'h2A;
        @(negedge clk); acc = cyc; char_in = 8'h2A;
        @(negedge clk); char_valid = 1'b0; char_in = 8'h00;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL t2_count got %0d exp 1", fifo_count); end
        wait_frames(2, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL t2_timeout got %0d frames exp 2", txq.size()); return; end
        f1 = txq.pop_front(); b = busyq.pop_front(); s1 = startq.pop_front();
        f2 = txq.pop_front(); b = busyq.pop_front(); s2 = startq.pop_front();
        checks++; if (f1 !== frame_of(8'h2A)) begin errors++; $display("[TB] FAIL t2_frame1 got %h exp %h", f1, frame_of(8'h2A)); end
        checks++; if (f2 !== frame_of(8'h2A)) begin errors++; $display("[TB] FAIL t2_frame2 got %h exp %h", f2, frame_of(8'h2A)); end
        checks++; if (s1 - acc !== 1) begin errors++; $display("[TB] FAIL t2_latency got %0d exp 1", s1 - acc); end
        checks++; if (s2 - s1 !== 40) begin errors++; $display("[TB] FAIL t2_gap got %0d exp 40", s2 - s1); end
        @(negedge clk);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL t2_count_end got %0d exp 0", fifo_count); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_busy_end got %b exp 0", tx_busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL t2_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_overflow();
        int acc, st;
        bit ok;
        logic [39:0] f, b;
        logic [7:0] c;
        @(negedge clk); char_valid = 1'b1; char_in = 8'h31;
        @(negedge clk); acc = cyc; char_in = 8'h32;
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL t3_first_pop got %b exp 0", tx); end
        char_in = 8'h33;
        @(negedge clk); char_in = 8'h34;
        @(negedge clk); char_in = 8'h35;
        @(negedge clk); char_in = 8'h36;
        @(negedge clk); char_valid = 1'b0; char_in = 8'h00;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL t3_count got %0d exp 4", fifo_count); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL t3_full got %b exp 1", fifo_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL t3_ovf got %b exp 1", overflow); end
        wait_frames(5, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL t3_timeout got %0d frames exp 5", txq.size()); return; end
        for (int i = 0; i < 5; i++) begin
            c = 8'h31 + 8'(i);
            f = txq.pop_front(); b = busyq.pop_front(); st = startq.pop_front();
            if (i == 0) begin
                checks++; if (st - acc !== 1) begin errors++; $display("[TB] FAIL t3_latency got %0d exp 1", st - acc); end
            end
            checks++; if (f !== frame_of(c)) begin errors++; $display("[TB] FAIL t3_frame%0d got %h exp %h", i, f, frame_of(c)); end
        end
        repeat (60) @(negedge clk);
        checks++; if (txq.size() !== 0) begin errors++; $display("[TB] FAIL t3_extra_frames got %0d exp 0", txq.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL t3_ovf_sticky got %b exp 1", overflow); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL t3_count_end got %0d exp 0", fifo_count); end
    endtask

    task automatic test_full_pop_write();
        int acc;
        bit ok;
        logic [39:0] f, b;
        logic [7:0] c;
        int st;
        apply_reset();
        @(negedge clk); char_valid = 1'b1; char_in = 8'hA1;
        @(negedge clk); acc = cyc; char_in = 8'hA2;
        @(negedge clk); char_in = 8'hA3;
        @(negedge clk); char_in = 8'hA4;
        @(negedge clk); char_in = 8'hA5;
        @(negedge clk); char_valid = 1'b0; char_in = 8'h00;
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL t4_full got %b exp 1", fifo_full); end
        while (cyc < acc + 40) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL t4_stop_tx got %b exp 1", tx); end
        char_valid = 1'b1; char_in = 8'hA6;
        @(negedge clk); char_valid = 1'b0; char_in = 8'h00;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL t4_count got %0d exp 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL t4_ovf got %b exp 0", overflow); end
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL t4_restart got %b exp 0", tx); end
        wait_frames(6, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL t4_timeout got %0d frames exp 6", txq.size()); return; end
        for (int i = 0; i < 6; i++) begin
            c = 8'hA1 + 8'(i);
            f = txq.pop_front(); b = busyq.pop_front(); st = startq.pop_front();
            checks++; if (f !== frame_of(c)) begin errors++; $display("[TB] FAIL t4_frame%0d got %h exp %h", i, f, frame_of(c)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc, st;
        bit ok;
        logic [39:0] f, b;
        apply_reset();
        @(negedge clk); char_valid = 1'b1; char_in = 8'h05;
        @(negedge clk); acc = cyc; char_in = 8'hC3;
        @(negedge clk); char_in = 8'h7E;
        @(negedge clk); char_valid = 1'b0; char_in = 8'h00;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL t5_count got %0d exp 2", fifo_count); end
        while (cyc < acc + 18) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("[TB] FAIL t5_bit3 got %b exp 0", tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL t5_abort_tx got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL t5_abort_busy got %b exp 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL t5_abort_count got %0d exp 0", fifo_count); end
        @(negedge clk);
        @(negedge clk);
        txq.delete(); busyq.delete(); startq.delete();
        rst_n = 1'b1; char_valid = 1'b1; char_in = 8'h55;
        @(negedge clk); acc = cyc; char_valid = 1'b0; char_in = 8'h00;
        wait_frames(1, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL t5_timeout got 0 frames exp 1"); return; end
        f = txq.pop_front(); b = busyq.pop_front(); st = startq.pop_front();
        checks++; if (f !== frame_of(8'h55)) begin errors++; $display("[TB] FAIL t5_frame got %h exp %h", f, frame_of(8'h55)); end
        checks++; if (st - acc !== 1) begin errors++; $display("[TB] FAIL t5_latency got %0d exp 1", st - acc); end
        repeat (60) @(negedge clk);
        checks++; if (txq.size() !== 0) begin errors++; $display("[TB] FAIL t5_stale_frames got %0d exp 0", txq.size()); end
    endtask

    task automatic test_pointer_wrap();
        int acc, st;
        bit ok;
        logic [39:0] f, b;
        logic [7:0] c;
        for (int i = 0; i < 12; i++) begin
            c = 8'(8'h10 + i * 19);
            write_char(c, acc);
            wait_frames(1, ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL t6_timeout%0d got 0 frames exp 1", i); return; end
            f = txq.pop_front(); b = busyq.pop_front(); st = startq.pop_front();
            checks++; if (f !== frame_of(c)) begin errors++; $display("[TB] FAIL t6_frame%0d got %h exp %h", i, f, frame_of(c)); end
        end
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL t6_ovf got %b exp 0", overflow); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL t6_count got %0d exp 0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_back_to_back();
        test_overflow();
        test_full_pop_write();
        test_reset_mid_frame();
        test_pointer_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
